// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the UART TX packet arbiter.
// Contents:
//   arb_state_t  FSM encoding (IDLE, HEADER, PASS)
//   HDR_MAGIC    upper nibble of the optional per-packet header byte
//   ABORT_W      width of the watchdog abort counter
package uart_tx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      PASS   = 2'd2
   } arb_state_t;

   localparam logic [3:0] HDR_MAGIC = 4'hA;
   localparam int         ABORT_W   = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker.
// Ports:
//   req  in   N    request vector
//   ptr  in   PW   index with highest priority this round
//   gnt  out  N    one-hot winner (0 when no request)
//   any  out  1    at least one request present
// Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1; the pointer register
// lives in the caller.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          any
);

   always_comb begin
      gnt = '0;
      any = 1'b0;
      // First pass: indices at or above the pointer.
      for (int j = 0; j < N; j++) begin
         if (!any && req[j] && (j >= int'(ptr))) begin
            gnt[j] = 1'b1;
            any    = 1'b1;
         end
      end
      // Second pass: wrap around to the indices below the pointer.
      for (int j = 0; j < N; j++) begin
         if (!any && req[j]) begin
            gnt[j] = 1'b1;
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one 8-bit AXI-Stream UART TX
// input between NUM_REQ sources. Whole tlast-delimited packets are granted;
// a stall watchdog drops a grant whose source stops presenting data.
// Ports:
//   clk            in   1           clock, posedge
//   arstn          in   1           asynchronous reset, active-low
//   s_axis_tdata   in   NUM_REQ*8   requester i byte at [8*i+:8]
//   s_axis_tvalid  in   NUM_REQ     per-requester valid
//   s_axis_tlast   in   NUM_REQ     per-requester end of packet
//   s_axis_tready  out  NUM_REQ     per-requester ready
//   m_axis_tdata   out  8           byte to UART TX
//   m_axis_tvalid  out  1           output valid
//   m_axis_tlast   out  1           last byte of granted packet
//   m_axis_tready  in   1           UART TX ready
//   grant          out  NUM_REQ     one-hot owner, 0 when idle
//   abort_count    out  16          saturating watchdog abort count
// Build option: UART_TX_ARB_HEADER_EN inserts one header byte
//   {HDR_MAGIC, 1'b0, owner[2:0]} ahead of every granted packet.
//
// state  | meaning
// IDLE   | no owner; arbitrate over s_axis_tvalid, register the winner
// HEADER | emit the header byte for the new owner (header build only)
// PASS   | owner's stream forwarded combinationally until tlast or abort
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                 clk,
   input  logic                 arstn,
   input  logic [NUM_REQ*8-1:0] s_axis_tdata,
   input  logic [NUM_REQ-1:0]   s_axis_tvalid,
   input  logic [NUM_REQ-1:0]   s_axis_tlast,
   output logic [NUM_REQ-1:0]   s_axis_tready,
   output logic [7:0]           m_axis_tdata,
   output logic                 m_axis_tvalid,
   output logic                 m_axis_tlast,
   input  logic                 m_axis_tready,
   output logic [NUM_REQ-1:0]   grant,
   output logic [ABORT_W-1:0]   abort_count
);

   localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

   arb_state_t         state, state_nxt;
   logic [PTR_W-1:0]   ptr, gidx, rr_idx, ptr_nxt;
   logic [NUM_REQ-1:0] rr_gnt;
   logic               rr_any;
   logic [WD_W-1:0]    wd_cnt;
   logic               sel_valid, sel_last;
   logic [7:0]         sel_data;
   logic               pkt_end, wd_fire;

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PTR_W)
   ) u_rr (
      .req (s_axis_tvalid),
      .ptr (ptr),
      .gnt (rr_gnt),
      .any (rr_any)
   );

   always_comb begin
      rr_idx = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (rr_gnt[j]) rr_idx = PTR_W'(j);
      end
   end

   assign sel_valid = s_axis_tvalid[gidx];
   assign sel_last  = s_axis_tlast[gidx];
   assign sel_data  = s_axis_tdata[{gidx, 3'b000} +: 8];
   assign ptr_nxt   = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;

   assign pkt_end = (state == PASS) && sel_valid && m_axis_tready && sel_last;
   // Backpressure is not a stall: the watchdog only advances while the
   // sink is ready and the owner has nothing to offer.
   assign wd_fire = WD_EN && (state == PASS) && !sel_valid && m_axis_tready &&
                    (wd_cnt == WD_LAST);

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (rr_any) begin
`ifdef UART_TX_ARB_HEADER_EN
               state_nxt = HEADER;
`else
               state_nxt = PASS;
`endif
            end
         end
         HEADER:  if (m_axis_tready) state_nxt = PASS;
         PASS:    if (pkt_end || wd_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      m_axis_tdata  = 8'h00;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      case (state)
`ifdef UART_TX_ARB_HEADER_EN
         HEADER: begin
            m_axis_tdata  = {HDR_MAGIC, 1'b0, 3'(gidx)};
            m_axis_tvalid = 1'b1;
         end
`endif
         PASS: begin
            m_axis_tdata  = sel_data;
            m_axis_tvalid = sel_valid;
            m_axis_tlast  = sel_last;
            s_axis_tready = grant & {NUM_REQ{m_axis_tready}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         grant       <= '0;
         gidx        <= '0;
         ptr         <= '0;
         wd_cnt      <= '0;
         abort_count <= '0;
      end else begin
         if (state == IDLE && rr_any) begin
            grant  <= rr_gnt;
            gidx   <= rr_idx;
            wd_cnt <= '0;
         end
         if (pkt_end || wd_fire) begin
            grant  <= '0;
            ptr    <= ptr_nxt;
            wd_cnt <= '0;
         end else if (state == PASS && WD_EN) begin
            if (sel_valid)          wd_cnt <= '0;
            else if (m_axis_tready) wd_cnt <= wd_cnt + 1'b1;
         end
         if (wd_fire && abort_count != {ABORT_W{1'b1}})
            abort_count <= abort_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

   localparam int N  = 3;
   localparam int TO = 10;
`ifdef UART_TX_ARB_HEADER_EN
   localparam bit HDR = 1'b1;
`else
   localparam bit HDR = 1'b0;
`endif

   logic clk = 1'b0;
   logic arstn = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]     src_data  [N];
   logic           src_valid [N];
   logic           src_last  [N];
   logic [N*8-1:0] s_tdata;
   logic [N-1:0]   s_tvalid, s_tlast, s_tready;
   logic [7:0]     m_tdata;
   logic           m_tvalid, m_tlast;
   logic           m_tready = 1'b1;
   logic [N-1:0]   grant;
   logic [15:0]    abort_count;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         s_tdata[8*i +: 8] = src_data[i];
         s_tvalid[i]       = src_valid[i];
         s_tlast[i]        = src_last[i];
      end
   end

   uart_tx_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .arstn         (arstn),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .grant         (grant),
      .abort_count   (abort_count)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]   d;
      logic         l;
      logic [N-1:0] g;
      int           c;
   } item_t;
   item_t mon_q[$];

   // Output values are stable between the negedge and the next posedge,
   // so a handshake seen here completes on the following edge.
   always @(negedge clk) begin
      if (arstn && m_tvalid && m_tready)
         mon_q.push_back('{d: m_tdata, l: m_tlast, g: grant, c: cyc});
   end

   initial begin
      #300000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   task automatic clear_src();
      for (int i = 0; i < N; i++) begin
         src_data[i]  = 8'h00;
         src_valid[i] = 1'b0;
         src_last[i]  = 1'b0;
      end
   endtask

   task automatic do_reset();
      arstn    = 1'b0;
      clear_src();
      m_tready = 1'b1;
      repeat (2) @(posedge clk);
      #1 arstn = 1'b1;
      mon_q.delete();
   endtask

   task automatic send(input int r, input int n, input logic [31:0] bytes, input bit last);
      bit hs;
      int w;
      for (int k = 0; k < n; k++) begin
         src_data[r]  = bytes[8*k +: 8];
         src_valid[r] = 1'b1;
         src_last[r]  = last && (k == n - 1);
         w  = 0;
         hs = 1'b0;
         do begin
            @(negedge clk);
            hs = s_tready[r];
            @(posedge clk);
            #1;
            w++;
         end while (!hs && w < 500);
         if (!hs) begin
            total++; bad++;
            $display("FAIL send_timeout req=%0d byte=%0d no ready within %0d cycles", r, k, w);
         end
      end
      src_valid[r] = 1'b0;
      src_last[r]  = 1'b0;
   endtask

   task automatic wait_items(input int n);
      int w = 0;
      while (mon_q.size() < n && w < 500) begin
         @(posedge clk);
         w++;
      end
      total++;
      if (mon_q.size() < n) begin
         bad++;
         $display("FAIL wait_items got=%0d want=%0d", mon_q.size(), n);
      end
   endtask

   task automatic test_reset();
      arstn = 1'b0;
      m_tready = 1'b1;
      for (int i = 0; i < N; i++) begin
         src_valid[i] = 1'b1;
         src_data[i]  = 8'hE0 + 8'(i);
         src_last[i]  = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      total++; if (grant !== 3'b000) begin bad++; $display("FAIL rst_grant got=%b want=000", grant); end
      total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_mvalid got=%b want=0", m_tvalid); end
      total++; if (s_tready !== 3'b000) begin bad++; $display("FAIL rst_sready got=%b want=000", s_tready); end
      total++; if (abort_count !== 16'h0000) begin bad++; $display("FAIL rst_abort got=%h want=0000", abort_count); end
      do_reset();
   endtask

   task automatic test_single();
      logic [7:0] ed[$]; logic el[$]; logic [N-1:0] eg[$];
      int t0;
      do_reset();
      t0 = cyc;
      if (HDR) begin ed.push_back(8'hA0); el.push_back(1'b0); eg.push_back(3'b001); end
      ed.push_back(8'h11); el.push_back(1'b0); eg.push_back(3'b001);
      ed.push_back(8'h22); el.push_back(1'b0); eg.push_back(3'b001);
      ed.push_back(8'h33); el.push_back(1'b1); eg.push_back(3'b001);
      send(0, 3, 32'h00332211, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      total++; if (mon_q.size() != ed.size()) begin bad++; $display("FAIL single_len got=%0d want=%0d", mon_q.size(), ed.size()); end
      for (int i = 0; i < ed.size() && i < mon_q.size(); i++) begin
         total++;
         if (mon_q[i].d !== ed[i] || mon_q[i].l !== el[i] || mon_q[i].g !== eg[i]) begin
            bad++;
            $display("FAIL single_item%0d got=%h/%b/%b want=%h/%b/%b", i, mon_q[i].d, mon_q[i].l, mon_q[i].g, ed[i], el[i], eg[i]);
         end
      end
      if (mon_q.size() > 0) begin
         total++;
         if (mon_q[0].c != t0 + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", mon_q[0].c - t0, 1); end
      end
      total++; if (grant !== 3'b000) begin bad++; $display("FAIL single_grant_end got=%b want=000", grant); end
   endtask

   task automatic test_contention();
      logic [7:0] ed[$]; logic el[$]; logic [N-1:0] eg[$];
      int ia;
      do_reset();
      if (HDR) begin ed.push_back(8'hA0); el.push_back(1'b0); eg.push_back(3'b001); end
      ed.push_back(8'hAA); el.push_back(1'b0); eg.push_back(3'b001);
      ed.push_back(8'hAB); el.push_back(1'b1); eg.push_back(3'b001);
      if (HDR) begin ed.push_back(8'hA1); el.push_back(1'b0); eg.push_back(3'b010); end
      ed.push_back(8'hBA); el.push_back(1'b0); eg.push_back(3'b010);
      ed.push_back(8'hBB); el.push_back(1'b1); eg.push_back(3'b010);
      fork
         send(0, 2, 32'h0000ABAA, 1'b1);
         send(1, 2, 32'h0000BBBA, 1'b1);
      join
      repeat (3) @(posedge clk);
      #1;
      total++; if (mon_q.size() != ed.size()) begin bad++; $display("FAIL cont_len got=%0d want=%0d", mon_q.size(), ed.size()); end
      for (int i = 0; i < ed.size() && i < mon_q.size(); i++) begin
         total++;
         if (mon_q[i].d !== ed[i] || mon_q[i].l !== el[i] || mon_q[i].g !== eg[i]) begin
            bad++;
            $display("FAIL cont_item%0d got=%h/%b/%b want=%h/%b/%b", i, mon_q[i].d, mon_q[i].l, mon_q[i].g, ed[i], el[i], eg[i]);
         end
      end
      ia = HDR ? 2 : 1;
      if (mon_q.size() > ia + 1) begin
         total++;
         if (mon_q[ia+1].c - mon_q[ia].c != 2) begin
            bad++;
            $display("FAIL cont_bubble got=%0d want=2 cycles", mon_q[ia+1].c - mon_q[ia].c);
         end
      end
   endtask

   task automatic test_fairness();
      logic [7:0] ed[$]; logic el[$]; logic [N-1:0] eg[$];
      do_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < N; r++) begin
            if (HDR) begin ed.push_back(8'hA0 + 8'(r)); el.push_back(1'b0); eg.push_back(3'(1 << r)); end
            ed.push_back(8'(16*r + k)); el.push_back(1'b1); eg.push_back(3'(1 << r));
         end
      end
      fork
         begin send(0, 1, 32'h00, 1'b1); send(0, 1, 32'h01, 1'b1); end
         begin send(1, 1, 32'h10, 1'b1); send(1, 1, 32'h11, 1'b1); end
         begin send(2, 1, 32'h20, 1'b1); send(2, 1, 32'h21, 1'b1); end
      join
      repeat (3) @(posedge clk);
      #1;
      total++; if (mon_q.size() != ed.size()) begin bad++; $display("FAIL fair_len got=%0d want=%0d", mon_q.size(), ed.size()); end
      for (int i = 0; i < ed.size() && i < mon_q.size(); i++) begin
         total++;
         if (mon_q[i].d !== ed[i] || mon_q[i].l !== el[i] || mon_q[i].g !== eg[i]) begin
            bad++;
            $display("FAIL fair_item%0d got=%h/%b/%b want=%h/%b/%b", i, mon_q[i].d, mon_q[i].l, mon_q[i].g, ed[i], el[i], eg[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] ed[$]; logic el[$];
      do_reset();
      if (HDR) begin ed.push_back(8'hA0); el.push_back(1'b0); end
      ed.push_back(8'h01); el.push_back(1'b0);
      ed.push_back(8'h02); el.push_back(1'b0);
      ed.push_back(8'h03); el.push_back(1'b1);
      fork
         send(0, 3, 32'h00030201, 1'b1);
         begin
            wait_items(HDR ? 2 : 1);
            #1 m_tready = 1'b0;
            repeat (100) @(posedge clk);
            @(negedge clk);
            total++; if (grant !== 3'b001) begin bad++; $display("FAIL bp_grant_held got=%b want=001", grant); end
            total++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h02) begin bad++; $display("FAIL bp_hold got=%b/%h want=1/02", m_tvalid, m_tdata); end
            @(posedge clk);
            #1 m_tready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      total++; if (abort_count !== 16'h0000) begin bad++; $display("FAIL bp_abort got=%h want=0000", abort_count); end
      total++; if (mon_q.size() != ed.size()) begin bad++; $display("FAIL bp_len got=%0d want=%0d", mon_q.size(), ed.size()); end
      for (int i = 0; i < ed.size() && i < mon_q.size(); i++) begin
         total++;
         if (mon_q[i].d !== ed[i] || mon_q[i].l !== el[i]) begin
            bad++;
            $display("FAIL bp_item%0d got=%h/%b want=%h/%b", i, mon_q[i].d, mon_q[i].l, ed[i], el[i]);
         end
      end
   endtask

   task automatic test_watchdog();
      logic [7:0] ed[$]; logic el[$]; logic [N-1:0] eg[$];
      do_reset();
      if (HDR) begin ed.push_back(8'hA1); el.push_back(1'b0); eg.push_back(3'b010); end
      ed.push_back(8'h77); el.push_back(1'b0); eg.push_back(3'b010);
      if (HDR) begin ed.push_back(8'hA0); el.push_back(1'b0); eg.push_back(3'b001); end
      ed.push_back(8'h5A); el.push_back(1'b1); eg.push_back(3'b001);
      send(1, 1, 32'h77, 1'b0);
      for (int i = 0; i <= TO; i++) begin
         @(negedge clk);
         if (i == TO - 1) begin
            total++; if (grant !== 3'b010) begin bad++; $display("FAIL wd_before got=%b want=010", grant); end
         end
         if (i == TO) begin
            total++; if (grant !== 3'b000) begin bad++; $display("FAIL wd_release got=%b want=000", grant); end
            total++; if (abort_count !== 16'h0001) begin bad++; $display("FAIL wd_count got=%h want=0001", abort_count); end
         end
      end
      @(posedge clk);
      #1;
      send(0, 1, 32'h5A, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      total++; if (abort_count !== 16'h0001) begin bad++; $display("FAIL wd_count_after got=%h want=0001", abort_count); end
      total++; if (mon_q.size() != ed.size()) begin bad++; $display("FAIL wd_len got=%0d want=%0d", mon_q.size(), ed.size()); end
      for (int i = 0; i < ed.size() && i < mon_q.size(); i++) begin
         total++;
         if (mon_q[i].d !== ed[i] || mon_q[i].l !== el[i] || mon_q[i].g !== eg[i]) begin
            bad++;
            $display("FAIL wd_item%0d got=%h/%b/%b want=%h/%b/%b", i, mon_q[i].d, mon_q[i].l, mon_q[i].g, ed[i], el[i], eg[i]);
         end
      end
   endtask

   task automatic test_header_req1();
      logic [7:0] ed[$]; logic el[$];
      do_reset();
      if (HDR) begin ed.push_back(8'hA1); el.push_back(1'b0); end
      ed.push_back(8'h55); el.push_back(1'b1);
      send(1, 1, 32'h55, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      total++; if (mon_q.size() != ed.size()) begin bad++; $display("FAIL hdr_len got=%0d want=%0d", mon_q.size(), ed.size()); end
      for (int i = 0; i < ed.size() && i < mon_q.size(); i++) begin
         total++;
         if (mon_q[i].d !== ed[i] || mon_q[i].l !== el[i]) begin
            bad++;
            $display("FAIL hdr_item%0d got=%h/%b want=%h/%b", i, mon_q[i].d, mon_q[i].l, ed[i], el[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      src_data[0]  = 8'hC1;
      src_last[0]  = 1'b0;
      src_valid[0] = 1'b1;
      wait_items(HDR ? 2 : 1);
      #1 src_data[0] = 8'hC2;
      @(negedge clk);
      total++; if (m_tvalid !== 1'b1 || m_tdata !== 8'hC2) begin bad++; $display("FAIL rmid_byte2 got=%b/%h want=1/c2", m_tvalid, m_tdata); end
      arstn = 1'b0;
      #1;
      total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rmid_mvalid got=%b want=0", m_tvalid); end
      total++; if (grant !== 3'b000) begin bad++; $display("FAIL rmid_grant got=%b want=000", grant); end
      total++; if (s_tready !== 3'b000) begin bad++; $display("FAIL rmid_sready got=%b want=000", s_tready); end
      clear_src();
      @(posedge clk);
      #1 arstn = 1'b1;
   endtask

   initial begin
      clear_src();
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_backpressure();
      test_watchdog();
      test_header_req1();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
